// File: rtl/uart_receiver.sv
// UART receive path: start, DATA_BITS data bits (LSB first), optional parity, one stop.
// Ports: clk, reset, Rx_EN, RxD, sample_ENABLE -> Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx_EN,
  input  logic                 RxD,
  input  logic                 sample_ENABLE,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR,
  output logic                 Rx_BUSY
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_END = BW'(DATA_BITS - 1);
  localparam logic          ODD_BIT = (PARITY_ODD != 0);
  localparam logic          HAS_PAR = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ppend_q, ppend_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 rxs;

  assign rxs = sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RxD;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ppend_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ppend_q <= ppend_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ppend_d = ppend_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    if (!Rx_EN) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
    end else if (sample_ENABLE) begin
      unique case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          // Mid start bit: a high line here was only a glitch.
          if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_END) begin
              bit_d   = '0;
              state_d = HAS_PAR ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            ppend_d = (^shift_q) ^ rxs ^ ODD_BIT;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is seen.
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            data_d  = shift_q;
            perr_d  = HAS_PAR & ppend_q;
            ferr_d  = ~rxs;
            valid_d = rxs & ~(HAS_PAR & ppend_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perr_q;
  assign Rx_FERROR = ferr_q;
  assign Rx_BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: 8E1, tick every 4 clk, 64 clk per bit.
// Directed scenarios then randomized frames against a frame-level reference model.
module tb_uart_receiver;

  localparam int BITCLK = 64;

  logic       clk;
  logic       reset;
  logic       Rx_EN;
  logic       RxD;
  logic       sample_ENABLE;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;
  logic       Rx_BUSY;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         vcount   = 0;
  logic [7:0] exp_data = 8'h00;
  logic       prev_valid = 1'b0;

  uart_receiver #(
    .DATA_BITS (8),
    .PARITY_EN (1),
    .PARITY_ODD(0),
    .OVERSAMPLE(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Rx_EN        (Rx_EN),
    .RxD          (RxD),
    .sample_ENABLE(sample_ENABLE),
    .Rx_DATA      (Rx_DATA),
    .Rx_VALID     (Rx_VALID),
    .Rx_PERROR    (Rx_PERROR),
    .Rx_FERROR    (Rx_FERROR),
    .Rx_BUSY      (Rx_BUSY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    sample_ENABLE = 1'b0;
    for (int k = 0; ; k = (k + 1) % 4) begin
      @(negedge clk);
      sample_ENABLE = (k == 3);
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: a VALID pulse must carry the expected byte, clean flags,
  // and last exactly one clk.
  initial begin
    forever begin
      @(negedge clk);
      if (Rx_VALID) begin
        vcount++;
        check("valid_data", {24'h0, Rx_DATA}, {24'h0, exp_data});
        check("valid_flags", {30'h0, Rx_PERROR, Rx_FERROR}, 32'h0);
        check("valid_width", {31'h0, prev_valid}, 32'h0);
      end
      prev_valid = Rx_VALID;
    end
  end

  task automatic drive_bit(input logic b);
    RxD = b;
    repeat (BITCLK) @(negedge clk);
  endtask

  // Frame-level model: even parity error = odd count of ones over data+parity.
  task automatic send_frame(input logic [7:0] d, input logic pbit,
                            input logic stopb, input int gap);
    int   ones;
    int   v0;
    logic e_pe;
    logic e_fe;
    logic e_v;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    ones += int'(pbit);
    e_pe = (ones % 2) != 0;
    e_fe = !stopb;
    e_v  = !e_pe && !e_fe;
    exp_data = d;
    v0 = vcount;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(stopb);
    check("frame_data", {24'h0, Rx_DATA}, {24'h0, d});
    check("frame_perr", {31'h0, Rx_PERROR}, {31'h0, e_pe});
    check("frame_ferr", {31'h0, Rx_FERROR}, {31'h0, e_fe});
    check("frame_vcnt", vcount - v0, {31'h0, e_v});
    if (stopb) check("frame_busy", {31'h0, Rx_BUSY}, 32'h0);
    RxD = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int          v0;
    logic        seen;
    logic [7:0]  d;
    logic        pb;
    logic        sb;
    int          gap;
    reset = 1'b1;
    Rx_EN = 1'b1;
    RxD   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'h0, Rx_DATA}, 32'h0);
    check("rst_flags", {28'h0, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY}, 32'h0);
    reset = 1'b0;
    repeat (BITCLK) @(negedge clk);

    // 1: good frame
    send_frame(8'hA5, 1'b0, 1'b1, BITCLK);
    check("s1_data", {24'h0, Rx_DATA}, 32'hA5);

    // 2: parity error, then a good frame clears it
    send_frame(8'h3C, 1'b1, 1'b1, BITCLK);
    check("s2_perr", {31'h0, Rx_PERROR}, 32'h1);
    send_frame(8'h11, 1'b0, 1'b1, BITCLK);
    check("s2_clear", {31'h0, Rx_PERROR}, 32'h0);

    // 3: framing error
    send_frame(8'h7E, 1'b0, 1'b0, 2 * BITCLK);
    check("s3_ferr", {31'h0, Rx_FERROR}, 32'h1);
    check("s3_data", {24'h0, Rx_DATA}, 32'h7E);

    // 4: glitch shorter than half a bit
    v0 = vcount;
    seen = 1'b0;
    RxD = 1'b0;
    repeat (20) @(negedge clk);
    RxD = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Rx_BUSY) seen = 1'b1;
    end
    check("s4_busy_seen", {31'h0, seen}, 32'h1);
    check("s4_busy_low", {31'h0, Rx_BUSY}, 32'h0);
    check("s4_no_valid", vcount - v0, 32'h0);
    check("s4_data", {24'h0, Rx_DATA}, 32'h7E);

    // 5: reset after 4 data bits of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    reset = 1'b1;
    #1;
    check("s5_data", {24'h0, Rx_DATA}, 32'h0);
    check("s5_flags", {28'h0, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY}, 32'h0);
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (BITCLK) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1, BITCLK);
    check("s5_after", {24'h0, Rx_DATA}, 32'h5A);

    // 6: back-to-back frames, then Rx_EN dropped mid third frame
    v0 = vcount;
    send_frame(8'h01, 1'b1, 1'b1, 0);
    send_frame(8'h80, 1'b1, 1'b1, 0);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    check("s6_busy_mid", {31'h0, Rx_BUSY}, 32'h1);
    Rx_EN = 1'b0;
    @(negedge clk);
    check("s6_busy_off", {31'h0, Rx_BUSY}, 32'h0);
    for (int i = 3; i < 8; i++) drive_bit(1'b0);
    RxD = 1'b1;
    repeat (3 * BITCLK) @(negedge clk);
    check("s6_vcount", vcount - v0, 32'h2);
    check("s6_data", {24'h0, Rx_DATA}, 32'h80);
    Rx_EN = 1'b1;
    repeat (BITCLK) @(negedge clk);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      d  = 8'($urandom);
      pb = (^d) ^ ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 7) != 0);
      gap = sb ? int'($urandom_range(0, 100)) : BITCLK + int'($urandom_range(0, 64));
      send_frame(d, pb, sb, gap);
    end
    repeat (BITCLK) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
